// File: rtl/mant_mul_seq_pkg.sv
// rtl/mant_mul_seq_pkg.sv - shared constants and state type for the sequential mantissa multiplier
package mant_mul_seq_pkg;

  localparam int MW_DEFAULT = 24;
  localparam int PW         = 2 * MW_DEFAULT;
  localparam int CNT_W      = $clog2(MW_DEFAULT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_25bit.sv
// rtl/adder_25bit.sv - ripple-carry adder, width defaults to 25 bits
module adder_25bit #(
  parameter int W = 25
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[W];

endmodule

// File: rtl/mant_mul_seq.sv
// rtl/mant_mul_seq.sv - MW x MW unsigned shift-add multiplier, one partial product per cycle
module mant_mul_seq
  import mant_mul_seq_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [MW-1:0]   a,
  input  logic [MW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*MW-1:0] product
);

  localparam int CW  = (MW == MW_DEFAULT) ? CNT_W : $clog2(MW + 1);
  localparam int PWL = (MW == MW_DEFAULT) ? PW : 2 * MW;

  state_t          r_state;
  state_t          w_next;
  logic [MW-1:0]   r_m;
  logic [MW-1:0]   r_q;
  logic [MW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [MW:0]     w_in1;
  logic [MW:0]     w_in2;
  logic [MW:0]     w_sum;
  logic            w_unused_cout;
  logic            w_last;

  assign w_in1  = {1'b0, r_acc};
  assign w_in2  = r_q[0] ? {1'b0, r_m} : '0;
  assign w_last = (r_cnt == CW'(MW - 1));

  // Carry-out never fires: ACC + M is at most 2^(MW+1) - 2.
  adder_25bit #(
    .W (MW + 1)
  ) u_add (
    .i_a    (w_in1),
    .i_b    (w_in2),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_unused_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Low product half shares the Q register: each step shifts one result bit in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m   <= a;
            r_q   <= b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_acc <= w_sum[MW:1];
          r_q   <= {w_sum[0], r_q[MW-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = PWL'({r_acc, r_q});

endmodule

// File: tb/tb_mant_mul_seq.sv
// tb/tb_mant_mul_seq.sv - directed vector bench for mant_mul_seq
module tb_mant_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] a;
  logic [23:0] b;
  logic        busy;
  logic        done;
  logic [47:0] product;

  int checks = 0;
  int errors = 0;

  mant_mul_seq #(.MW(24)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one multiply; dist_step > 0 pulses start and scrambles a/b at that step.
  task automatic do_op(input logic [23:0] ia, input logic [23:0] ib, input int dist_step,
                       output logic [47:0] prod, output int lat, output int bcnt, output int dcnt);
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcnt  = busy ? 1 : 0;
    lat   = 0;
    dcnt  = 0;
    prod  = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == dist_step) begin
        start = 1'b1;
        a     = 24'hFFFFFF;
        b     = 24'hFFFFFF;
      end else if (k == dist_step + 1) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat  = k;
          prod = product;
        end
      end
    end
  endtask

  logic [47:0] prod;
  int          lat;
  int          bcnt;
  int          dcnt;
  int          done_at[$];
  logic [47:0] done_prod[$];

  initial begin
    vecs[0] = '{24'd3,       24'd5,       48'h00000000000F};
    vecs[1] = '{24'hFFFFFF,  24'hFFFFFF,  48'hFFFFFE000001};
    vecs[2] = '{24'h800000,  24'h800000,  48'h400000000000};
    vecs[3] = '{24'hC00000,  24'hC00000,  48'h900000000000};
    vecs[4] = '{24'h000000,  24'hFFFFFF,  48'h000000000000};
    vecs[5] = '{24'hFFFFFF,  24'h000000,  48'h000000000000};
    vecs[6] = '{24'd1000,    24'd1000,    48'h0000000F4240};
    vecs[7] = '{24'h800000,  24'd2,       48'h000001000000};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", 64'(product), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, 0, prod, lat, bcnt, dcnt);
      chk($sformatf("vec%0d_product", i), 64'(prod), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_done_count", i), 64'(dcnt), 64'd1);
      chk($sformatf("vec%0d_held", i), 64'(product), 64'(vecs[i].exp));
      if (i == 0) begin
        chk("latency_edges_after_accept", 64'(lat), 64'd24);
        chk("busy_cycles", 64'(bcnt), 64'd25);
      end
    end

    do_op(24'd7, 24'd9, 5, prod, lat, bcnt, dcnt);
    chk("ignored_inputs_product", 64'(prod), 64'd63);
    chk("ignored_inputs_done_count", 64'(dcnt), 64'd1);
    chk("ignored_inputs_latency", 64'(lat), 64'd24);

    @(negedge clk);
    start = 1'b1;
    a     = 24'd11;
    b     = 24'd13;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    dcnt = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    do_op(24'd6, 24'd7, 0, prod, lat, bcnt, dcnt);
    chk("after_abort_product", 64'(prod), 64'd42);
    chk("after_abort_latency", 64'(lat), 64'd24);

    @(negedge clk);
    start = 1'b1;
    a     = 24'd2;
    b     = 24'd2;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_at.push_back(k);
        done_prod.push_back(product);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_count", 64'(done_at.size()), 64'd3);
    if (done_at.size() == 3) begin
      chk("b2b_first_done", 64'(done_at[0]), 64'd24);
      chk("b2b_period_1", 64'(done_at[1] - done_at[0]), 64'd26);
      chk("b2b_period_2", 64'(done_at[2] - done_at[1]), 64'd26);
    end
    for (int i = 0; i < done_prod.size(); i++) begin
      chk($sformatf("b2b_product_%0d", i), 64'(done_prod[i]), 64'd4);
    end
    repeat (30) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
